// File: rtl/d_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package d_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [3:0] BE_ALL      = 4'b1111;
  localparam logic       WEN_WRITE   = 1'b0;
  localparam int         DEF_LATENCY = 2;

  // Expand 4 byte-lane enables into a 32-bit data mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/d_mem_responder_if.sv
// Core-side data-memory port: request/ready handshake with byte lanes.
interface d_mem_responder_if #(parameter int ADDR_W = 16);
  logic              D_MEM_CSN;
  logic              D_MEM_REQ;
  logic              D_MEM_WEN;
  logic [3:0]        D_MEM_BE;
  logic [ADDR_W-1:0] D_MEM_ADDR;
  logic [31:0]       D_MEM_DOUT;
  logic [31:0]       D_MEM_DI;
  logic              D_MEM_READY;
  logic              D_MEM_ERR;

  modport master (
    output D_MEM_CSN, D_MEM_REQ, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT,
    input  D_MEM_DI, D_MEM_READY, D_MEM_ERR
  );

  modport slave (
    input  D_MEM_CSN, D_MEM_REQ, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT,
    output D_MEM_DI, D_MEM_READY, D_MEM_ERR
  );
endinterface

// File: rtl/d_mem_array.sv
// DEPTH x 32 word storage: byte-enabled write and read share one enable; contents never reset.
module d_mem_array #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read returns the pre-write word when both happen on the same edge.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i)
        for (int i = 0; i < 4; i++)
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/d_mem_responder.sv
// Data-memory responder: FSM with wait states, error decode, registered response and access counter.
module d_mem_responder
  import d_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               CLK,
  input  logic               RSTn,
  d_mem_responder_if.slave   bus,
  output logic [31:0]        NUM_ACCESS
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdat_q;
  logic [31:0]       mask_q, mask_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic [31:0]       num_q;
  logic [31:0]       rdata;

  logic              accept, go_resp;
  logic              c_wen, c_err;
  logic [3:0]        c_be;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdat;

  assign accept = (state_q == IDLE) && !bus.D_MEM_CSN && bus.D_MEM_REQ;

  // With zero latency the access happens on the acceptance edge, so use the live inputs there.
  always_comb begin
    c_wen  = wen_q;
    c_be   = be_q;
    c_addr = addr_q;
    c_wdat = wdat_q;
    if (state_q == IDLE) begin
      c_wen  = bus.D_MEM_WEN;
      c_be   = bus.D_MEM_BE;
      c_addr = bus.D_MEM_ADDR;
      c_wdat = bus.D_MEM_DOUT;
    end
  end

  assign c_err = (c_addr[1:0] != 2'b00) || (32'(c_addr >> 2) >= 32'(DEPTH));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        cnt_d   = 4'(LATENCY);
        state_d = (LATENCY == 0) ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign go_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    ready_d = go_resp;
    err_d   = err_q;
    mask_d  = mask_q;
    if (go_resp) begin
      err_d  = c_err;
      mask_d = c_err ? 32'h0 : be_mask(c_be);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wen_q   <= 1'b1;
      be_q    <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      num_q   <= '0;
    end else begin
      if (accept) begin
        wen_q  <= bus.D_MEM_WEN;
        be_q   <= bus.D_MEM_BE;
        addr_q <= bus.D_MEM_ADDR;
        wdat_q <= bus.D_MEM_DOUT;
      end
      mask_q  <= mask_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      if (state_q == RESP) num_q <= num_q + 32'd1;
    end
  end

  d_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (CLK),
    .en_i    (go_resp && !c_err),
    .we_i    (go_resp && !c_err && (c_wen == WEN_WRITE)),
    .be_i    (c_be),
    .addr_i  (c_addr[AW+1:2]),
    .wdata_i (c_wdat),
    .rdata_o (rdata)
  );

  // Array output holds between enables; the registered mask zeroes disabled lanes and errors.
  assign bus.D_MEM_DI    = rdata & mask_q;
  assign bus.D_MEM_READY = ready_q;
  assign bus.D_MEM_ERR   = err_q;
  assign NUM_ACCESS      = num_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// Self-checking bench: vector table through a scoreboard plus reset, throughput and ignore sequences.
module tb_d_mem_responder;
  import d_mem_pkg::*;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  d_mem_responder_if #(.ADDR_W(16)) bus ();
  d_mem_responder_if #(.ADDR_W(16)) bus0 ();
  logic [31:0] num, num0;

  d_mem_responder #(.ADDR_W(16), .DEPTH(1024), .LATENCY(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(bus.slave), .NUM_ACCESS(num));
  d_mem_responder #(.ADDR_W(16), .DEPTH(1024), .LATENCY(0)) dut0 (
    .CLK(CLK), .RSTn(RSTn), .bus(bus0.slave), .NUM_ACCESS(num0));

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;
  int exp_num = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] di;
    logic        err;
    logic        chk_di;
    int          acc;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;

  typedef struct {
    string       name;
    logic        wen;
    logic [3:0]  be;
    logic [15:0] addr;
    logic [31:0] dout;
    logic [31:0] di;
    logic        err;
    logic        chk_di;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor: every READY pulse must match the oldest outstanding access.
  always @(negedge CLK) begin
    if (bus.D_MEM_READY !== 1'b0) begin
      if (sb.size() == 0) chk("unexpected READY", 32'(bus.D_MEM_READY), 32'h0);
      else begin
        e_m = sb.pop_front();
        chk({e_m.name, " ERR"}, 32'(bus.D_MEM_ERR), 32'(e_m.err));
        if (e_m.chk_di) chk({e_m.name, " DI"}, bus.D_MEM_DI, e_m.di);
        chk({e_m.name, " latency"}, 32'(cyc - e_m.acc), 32'd2);
      end
    end
  end

  task automatic drive(input logic wen, input logic [3:0] be, input logic [15:0] addr,
                       input logic [31:0] dout);
    bus.D_MEM_CSN  = 1'b0;
    bus.D_MEM_REQ  = 1'b1;
    bus.D_MEM_WEN  = wen;
    bus.D_MEM_BE   = be;
    bus.D_MEM_ADDR = addr;
    bus.D_MEM_DOUT = dout;
  endtask

  task automatic access(input string nm, input logic wen, input logic [3:0] be,
                        input logic [15:0] addr, input logic [31:0] dout,
                        input logic [31:0] edi, input logic eerr, input logic cdi,
                        input bit poke);
    exp_t e;
    @(negedge CLK);
    drive(wen, be, addr, dout);
    @(posedge CLK);
    #1;
    e = '{di: edi, err: eerr, chk_di: cdi, acc: cyc, name: nm};
    sb.push_back(e);
    exp_num++;
    bus.D_MEM_REQ = 1'b0;
    bus.D_MEM_CSN = 1'b1;
    if (poke) begin
      // New request and changed inputs while BUSY must be ignored.
      @(negedge CLK);
      drive(WEN_WRITE, BE_ALL, addr + 16'd4, ~dout);
      @(negedge CLK);
      bus.D_MEM_REQ = 1'b0;
      bus.D_MEM_CSN = 1'b1;
    end
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      chk({"timeout ", nm}, 32'(sb.size()), 32'h0);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    tbl[0]  = '{"w0 init",     1'b0, 4'hF, 16'h0000, 32'h0BADF00D, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{"w40",         1'b0, 4'hF, 16'h0040, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{"r40",         1'b1, 4'hF, 16'h0040, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[3]  = '{"w80 full",    1'b0, 4'hF, 16'h0080, 32'h11223344, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{"w80 be0101",  1'b0, 4'h5, 16'h0080, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0};
    tbl[5]  = '{"r80 full",    1'b1, 4'hF, 16'h0080, 32'h0,        32'h11BB33DD, 1'b0, 1'b1};
    tbl[6]  = '{"r80 be0011",  1'b1, 4'h3, 16'h0080, 32'h0,        32'h000033DD, 1'b0, 1'b1};
    tbl[7]  = '{"r42 misalign",1'b1, 4'hF, 16'h0042, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[8]  = '{"w1000 range", 1'b0, 4'hF, 16'h1000, 32'h12345678, 32'h0,        1'b1, 1'b1};
    tbl[9]  = '{"r0 unchanged",1'b1, 4'hF, 16'h0000, 32'h0,        32'h0BADF00D, 1'b0, 1'b1};
    tbl[10] = '{"w84",         1'b0, 4'hF, 16'h0084, 32'h55667788, 32'h0,        1'b0, 1'b0};
    tbl[11] = '{"w84 be0",     1'b0, 4'h0, 16'h0084, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
    tbl[12] = '{"r84",         1'b1, 4'hF, 16'h0084, 32'h0,        32'h55667788, 1'b0, 1'b1};
    tbl[13] = '{"wFFC last",   1'b0, 4'hF, 16'h0FFC, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    tbl[14] = '{"rFFC last",   1'b1, 4'hF, 16'h0FFC, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[15] = '{"rFFE misalign",1'b1,4'hF, 16'h0FFE, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[16] = '{"r80 be1000",  1'b1, 4'h8, 16'h0080, 32'h0,        32'h11000000, 1'b0, 1'b1};

    bus.D_MEM_CSN = 1'b1;  bus.D_MEM_REQ = 1'b0;  bus.D_MEM_WEN = 1'b1;
    bus.D_MEM_BE  = 4'h0;  bus.D_MEM_ADDR = '0;   bus.D_MEM_DOUT = '0;
    bus0.D_MEM_CSN = 1'b1; bus0.D_MEM_REQ = 1'b0; bus0.D_MEM_WEN = 1'b1;
    bus0.D_MEM_BE  = 4'h0; bus0.D_MEM_ADDR = '0;  bus0.D_MEM_DOUT = '0;

    repeat (2) @(negedge CLK);
    chk("reset READY", 32'(bus.D_MEM_READY), 32'h0);
    chk("reset ERR",   32'(bus.D_MEM_ERR),   32'h0);
    chk("reset DI",    bus.D_MEM_DI,         32'h0);
    chk("reset NUM",   num,                  32'h0);
    chk("reset NUM0",  num0,                 32'h0);
    RSTn = 1'b1;

    // Reset during BUSY of a write aborts it.
    access("w10 prior", 1'b0, 4'hF, 16'h0010, 32'h13572468, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    drive(WEN_WRITE, BE_ALL, 16'h0010, 32'hCAFEF00D);
    @(posedge CLK);
    #1;
    bus.D_MEM_REQ = 1'b0;
    bus.D_MEM_CSN = 1'b1;
    @(negedge CLK);
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort READY", 32'(bus.D_MEM_READY), 32'h0);
    chk("abort NUM",   num,                  32'h0);
    chk("abort DI",    bus.D_MEM_DI,         32'h0);
    RSTn = 1'b1;
    exp_num = 0;
    access("r10 after abort", 1'b1, 4'hF, 16'h0010, 32'h0, 32'h13572468, 1'b0, 1'b1, 1'b0);

    foreach (tbl[i])
      access(tbl[i].name, tbl[i].wen, tbl[i].be, tbl[i].addr, tbl[i].dout,
             tbl[i].di, tbl[i].err, tbl[i].chk_di, 1'b0);
    chk("NUM after table", num, 32'(exp_num));

    // Request pulsed during BUSY, with other inputs changed.
    access("w48 prior", 1'b0, 4'hF, 16'h0048, 32'h0A0B0C0D, 32'h0, 1'b0, 1'b0, 1'b0);
    access("w44 poked", 1'b0, 4'hF, 16'h0044, 32'h01020304, 32'h0, 1'b0, 1'b0, 1'b1);
    access("r44",       1'b1, 4'hF, 16'h0044, 32'h0, 32'h01020304, 1'b0, 1'b1, 1'b0);
    access("r48",       1'b1, 4'hF, 16'h0048, 32'h0, 32'h0A0B0C0D, 1'b0, 1'b1, 1'b0);
    chk("NUM after poke", num, 32'(exp_num));

    // CSN high with REQ high is ignored.
    @(negedge CLK);
    drive(WEN_WRITE, BE_ALL, 16'h0040, 32'h0);
    bus.D_MEM_CSN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("csn READY", 32'(bus.D_MEM_READY), 32'h0);
    end
    bus.D_MEM_REQ = 1'b0;
    chk("csn NUM", num, 32'(exp_num));
    access("r40 after csn", 1'b1, 4'hF, 16'h0040, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);

    // Zero latency, REQ held: one response every second cycle.
    @(negedge CLK);
    bus0.D_MEM_CSN = 1'b0; bus0.D_MEM_REQ = 1'b1; bus0.D_MEM_WEN = 1'b1;
    bus0.D_MEM_BE = BE_ALL; bus0.D_MEM_ADDR = 16'h0040;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("lat0 READY", 32'(bus0.D_MEM_READY), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    bus0.D_MEM_REQ = 1'b0;
    bus0.D_MEM_CSN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("lat0 NUM", num0, 32'd5);
    chk("final NUM", num, 32'(exp_num));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
